// File: rtl/ravenoc_pkg.sv
// Shared NoC interface types: VC flit request bundle, TX scheduler states and
// default sizing constants used by the NI transmit path and AXI write buffers.
package ravenoc_pkg;

    localparam int NumVcDef         = 2;
    localparam int PktWidthDef      = 8;
    localparam int FlitDataWidthDef = 32;
    localparam int VcWidth          = $clog2(NumVcDef);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } tx_sched_st_t;

    typedef struct packed {
        logic                        valid;
        logic [FlitDataWidthDef-1:0] data;
        logic [PktWidthDef-1:0]      pkt_sz;
    } s_vc_flit_req_t;

endpackage

// File: rtl/tx_vc_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after
// the pointer, searching upward with wrap (works for non-power-of-2 counts).
module rr_arbiter #(
    parameter  int NumReq   = 2,
    localparam int IdxWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] ptr,
    output logic [NumReq-1:0]   grant,
    output logic [IdxWidth-1:0] idx,
    output logic                any
);

    int                  cand_int;
    logic [IdxWidth-1:0] cand;

    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand_int = 0;
        cand     = '0;
        for (int i = 0; i < NumReq; i++) begin
            // Wrap explicitly so non-power-of-2 request counts stay in range.
            cand_int = int'(ptr) + i;
            if (cand_int >= NumReq) begin
                cand_int = cand_int - NumReq;
            end
            cand = IdxWidth'(cand_int);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/tx_vc_sched.sv
// Packet-granular round-robin scheduler multiplexing per-VC flit sources onto
// the single NoC send port; a granted VC owns the port until its last flit.
module tx_vc_sched #(
    parameter  int NumVC         = 2,
    parameter  int PktWidth      = 8,
    parameter  int FlitDataWidth = 32,
    localparam int VcWidth       = $clog2(NumVC)
) (
    input  logic                            clk_axi,
    input  logic                            rst_axi_n,
    input  logic [NumVC-1:0]                vc_en_i,
    input  logic [NumVC-1:0]                req_valid_i,
    input  logic [NumVC*FlitDataWidth-1:0]  req_data_i,
    input  logic [NumVC*PktWidth-1:0]       req_pkt_sz_i,
    output logic [NumVC-1:0]                req_ready_o,
    output logic                            out_valid_o,
    output logic [FlitDataWidth-1:0]        out_data_o,
    output logic [VcWidth-1:0]              out_vc_id_o,
    output logic [PktWidth-1:0]             out_pkt_sz_o,
    input  logic                            out_ready_i,
    output logic                            busy_o
);

    import ravenoc_pkg::*;

    tx_sched_st_t         state, state_nxt;
    logic [VcWidth-1:0]   rr_ptr, rr_ptr_nxt;
    logic [VcWidth-1:0]   grant_ff, grant_nxt;
    logic [PktWidth-1:0]  cnt_ff, cnt_nxt;

    logic [FlitDataWidth-1:0] data_arr [NumVC];
    logic [PktWidth-1:0]      sz_arr   [NumVC];

    logic [NumVC-1:0]         candidates;
    logic [NumVC-1:0]         arb_grant;
    logic [VcWidth-1:0]       arb_idx;
    logic                     arb_any;

    logic [VcWidth-1:0]       fwd_vc;
    logic [NumVC-1:0]         fwd_sel;
    logic                     fwd_active;
    logic                     fwd_valid;
    logic                     accept;

    for (genvar g = 0; g < NumVC; g++) begin : g_unpack
        assign data_arr[g] = req_data_i[g*FlitDataWidth +: FlitDataWidth];
        assign sz_arr[g]   = req_pkt_sz_i[g*PktWidth +: PktWidth];
    end

    assign candidates = req_valid_i & vc_en_i;

    rr_arbiter #(
        .NumReq (NumVC)
    ) u_rr_arbiter (
        .req   (candidates),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    function automatic logic [VcWidth-1:0] vc_inc(input logic [VcWidth-1:0] v);
        return (v == VcWidth'(NumVC - 1)) ? '0 : v + VcWidth'(1);
    endfunction

    // While locked the arbiter result is ignored; only the owning VC is muxed.
    always_comb begin
        fwd_vc     = arb_idx;
        fwd_sel    = arb_grant;
        fwd_active = arb_any;
        if (state == LOCKED) begin
            fwd_vc           = grant_ff;
            fwd_sel          = '0;
            fwd_sel[grant_ff] = 1'b1;
            fwd_active       = 1'b1;
        end
        fwd_valid = fwd_active & req_valid_i[fwd_vc];
    end

    always_comb begin
        out_valid_o  = rst_axi_n & fwd_valid;
        out_data_o   = rst_axi_n ? data_arr[fwd_vc] : '0;
        out_pkt_sz_o = rst_axi_n ? sz_arr[fwd_vc] : '0;
        out_vc_id_o  = rst_axi_n ? fwd_vc : '0;
        req_ready_o  = (rst_axi_n && fwd_active) ? (fwd_sel & {NumVC{out_ready_i}}) : '0;
        busy_o       = rst_axi_n & (state == LOCKED);
    end

    assign accept = out_valid_o & out_ready_i;

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_ff;
        cnt_nxt    = cnt_ff;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sz_arr[arb_idx] == '0) begin
                        rr_ptr_nxt = vc_inc(arb_idx);
                    end else begin
                        state_nxt = LOCKED;
                        grant_nxt = arb_idx;
                        cnt_nxt   = sz_arr[arb_idx];
                    end
                end
            end
            LOCKED: begin
                if (accept) begin
                    if (cnt_ff == PktWidth'(1)) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = vc_inc(grant_ff);
                    end else begin
                        cnt_nxt = cnt_ff - PktWidth'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_axi) begin
        if (!rst_axi_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_ff <= '0;
            cnt_ff   <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_ff <= grant_nxt;
            cnt_ff   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_tx_vc_sched.sv
// Directed scenario bench for tx_vc_sched with four VCs; every scenario task
// drives its own vectors and compares against hand-derived expectations.
module tb_tx_vc_sched;

    localparam int NumVC         = 4;
    localparam int PktWidth      = 8;
    localparam int FlitDataWidth = 32;

    logic                           clk_axi = 1'b0;
    logic                           rst_axi_n;
    logic [NumVC-1:0]               vc_en;
    logic [NumVC-1:0]               req_valid;
    logic [NumVC*FlitDataWidth-1:0] req_data;
    logic [NumVC*PktWidth-1:0]      req_pkt_sz;
    logic [NumVC-1:0]               req_ready;
    logic                           out_valid;
    logic [FlitDataWidth-1:0]       out_data;
    logic [1:0]                     out_vc_id;
    logic [PktWidth-1:0]            out_pkt_sz;
    logic                           out_ready;
    logic                           busy;

    logic [FlitDataWidth-1:0] data_arr [NumVC];
    logic [PktWidth-1:0]      sz_arr   [NumVC];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < NumVC; g++) begin : g_pack
        assign req_data[g*FlitDataWidth +: FlitDataWidth] = data_arr[g];
        assign req_pkt_sz[g*PktWidth +: PktWidth]         = sz_arr[g];
    end

    tx_vc_sched #(
        .NumVC         (NumVC),
        .PktWidth      (PktWidth),
        .FlitDataWidth (FlitDataWidth)
    ) dut (
        .clk_axi      (clk_axi),
        .rst_axi_n    (rst_axi_n),
        .vc_en_i      (vc_en),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_pkt_sz_i (req_pkt_sz),
        .req_ready_o  (req_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_vc_id_o  (out_vc_id),
        .out_pkt_sz_o (out_pkt_sz),
        .out_ready_i  (out_ready),
        .busy_o       (busy)
    );

    always #5 clk_axi = ~clk_axi;

    function automatic logic [FlitDataWidth-1:0] exp_data(input logic [1:0] vc);
        return 32'hD000_0000 | {30'd0, vc};
    endfunction

    task automatic tick();
        @(posedge clk_axi);
        #1;
    endtask

    task automatic set_vc(input logic [1:0] vc, input logic v, input logic [PktWidth-1:0] sz);
        req_valid[vc] = v;
        sz_arr[vc]    = sz;
    endtask

    task automatic reset_dut();
        rst_axi_n = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        vc_en     = '1;
        tick();
        rst_axi_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_axi_n = 1'b0;
        vc_en     = '1;
        out_ready = 1'b1;
        for (int i = 0; i < NumVC; i++) set_vc(2'(i), 1'b1, 8'd4);
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_vc_id !== 2'd0) begin failures++; $display("FAIL reset_vc_id got=%0d exp=0", out_vc_id); end
        checks++; if (out_pkt_sz !== 8'd0) begin failures++; $display("FAIL reset_pkt_sz got=%0d exp=0", out_pkt_sz); end
        rst_axi_n = 1'b1;
        req_valid = '0;
    endtask

    task automatic test_two_vc_rr();
        logic [1:0] exp_vc;
        logic       exp_busy;
        reset_dut();
        set_vc(2'd0, 1'b1, 8'd2);
        set_vc(2'd1, 1'b1, 8'd2);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_vc   = (c < 3) ? 2'd0 : 2'd1;
            exp_busy = (c == 1 || c == 2 || c == 4 || c == 5);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rr2_valid c=%0d got=%0b exp=1", c, out_valid); end
            checks++; if (out_vc_id !== exp_vc) begin failures++; $display("FAIL rr2_vc c=%0d got=%0d exp=%0d", c, out_vc_id, exp_vc); end
            checks++; if (out_data !== exp_data(exp_vc)) begin failures++; $display("FAIL rr2_data c=%0d got=%h exp=%h", c, out_data, exp_data(exp_vc)); end
            checks++; if (out_pkt_sz !== 8'd2) begin failures++; $display("FAIL rr2_pkt_sz c=%0d got=%0d exp=2", c, out_pkt_sz); end
            checks++; if (req_ready !== (4'b0001 << exp_vc)) begin failures++; $display("FAIL rr2_ready c=%0d got=%b exp=%b", c, req_ready, 4'b0001 << exp_vc); end
            checks++; if (busy !== exp_busy) begin failures++; $display("FAIL rr2_busy c=%0d got=%0b exp=%0b", c, busy, exp_busy); end
            tick();
        end
        req_valid = '0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr2_busy_end got=%0b exp=0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rr2_valid_end got=%0b exp=0", out_valid); end
    endtask

    task automatic test_ready_toggle();
        int acc;
        acc = 0;
        reset_dut();
        set_vc(2'd1, 1'b1, 8'd3);
        for (int c = 0; c < 7; c++) begin
            out_ready = (c % 2 == 0);
            if (c > 0) set_vc(2'd0, 1'b1, 8'd0);
            #1;
            checks++; if (out_vc_id !== 2'd1) begin failures++; $display("FAIL tog_vc c=%0d got=%0d exp=1", c, out_vc_id); end
            checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL tog_ready0 c=%0d got=%0b exp=0", c, req_ready[0]); end
            checks++; if (req_ready[1] !== out_ready) begin failures++; $display("FAIL tog_ready1 c=%0d got=%0b exp=%0b", c, req_ready[1], out_ready); end
            if (out_valid && out_ready && out_vc_id == 2'd1) acc++;
            tick();
        end
        out_ready = 1'b0;
        #1;
        checks++; if (acc != 4) begin failures++; $display("FAIL tog_accepts got=%0d exp=4", acc); end
        checks++; if (out_vc_id !== 2'd0) begin failures++; $display("FAIL tog_next_vc got=%0d exp=0", out_vc_id); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tog_busy_end got=%0b exp=0", busy); end
    endtask

    task automatic test_single_flit();
        reset_dut();
        for (int i = 0; i < NumVC; i++) set_vc(2'(i), 1'b1, 8'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (out_vc_id !== 2'(c % 4)) begin failures++; $display("FAIL sf_vc c=%0d got=%0d exp=%0d", c, out_vc_id, c % 4); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sf_valid c=%0d got=%0b exp=1", c, out_valid); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sf_busy c=%0d got=%0b exp=0", c, busy); end
            tick();
        end
    endtask

    task automatic test_vc_enable();
        logic [1:0] seq_a [6] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
        logic [1:0] seq_b [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        logic       busy_b [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        reset_dut();
        vc_en = 4'b1101;
        for (int i = 0; i < NumVC; i++) set_vc(2'(i), 1'b1, 8'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (out_vc_id !== seq_a[c]) begin failures++; $display("FAIL en_mask_vc c=%0d got=%0d exp=%0d", c, out_vc_id, seq_a[c]); end
            tick();
        end
        reset_dut();
        set_vc(2'd0, 1'b1, 8'd2);
        for (int i = 1; i < NumVC; i++) set_vc(2'(i), 1'b1, 8'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 1) vc_en = 4'b1110;
            #1;
            checks++; if (out_vc_id !== seq_b[c]) begin failures++; $display("FAIL en_lock_vc c=%0d got=%0d exp=%0d", c, out_vc_id, seq_b[c]); end
            checks++; if (busy !== busy_b[c]) begin failures++; $display("FAIL en_lock_busy c=%0d got=%0b exp=%0b", c, busy, busy_b[c]); end
            tick();
        end
    endtask

    task automatic test_valid_drop();
        reset_dut();
        set_vc(2'd2, 1'b1, 8'd3);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) begin
                set_vc(2'd0, 1'b1, 8'd0);
                set_vc(2'd1, 1'b1, 8'd0);
                set_vc(2'd3, 1'b1, 8'd0);
            end
            req_valid[2] = !(c >= 2 && c <= 4);
            #1;
            if (c >= 2 && c <= 4) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drop_valid c=%0d got=%0b exp=0", c, out_valid); end
                checks++; if ((req_ready & 4'b1011) !== 4'b0000) begin failures++; $display("FAIL drop_others_ready c=%0d got=%b exp=0x00", c, req_ready); end
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy c=%0d got=%0b exp=1", c, busy); end
            end else if (c < 7) begin
                checks++; if (out_vc_id !== 2'd2 || out_valid !== 1'b1) begin failures++; $display("FAIL drop_fwd c=%0d got=vc%0d/v%0b exp=vc2/v1", c, out_vc_id, out_valid); end
            end else begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy_end got=%0b exp=0", busy); end
                checks++; if (out_vc_id !== 2'd3) begin failures++; $display("FAIL drop_next_vc got=%0d exp=3", out_vc_id); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_packet();
        reset_dut();
        set_vc(2'd1, 1'b1, 8'd5);
        out_ready = 1'b1;
        #1;
        checks++; if (out_vc_id !== 2'd1) begin failures++; $display("FAIL rmp_head_vc got=%0d exp=1", out_vc_id); end
        tick();
        rst_axi_n = 1'b0;
        set_vc(2'd0, 1'b1, 8'd0);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmp_in_reset_valid got=%0b exp=0", out_valid); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rmp_in_reset_ready got=%b exp=0000", req_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmp_in_reset_busy got=%0b exp=0", busy); end
        tick();
        checks++; if (out_data !== 32'd0 || out_pkt_sz !== 8'd0) begin failures++; $display("FAIL rmp_after_edge_zero got=%h/%0d exp=0/0", out_data, out_pkt_sz); end
        rst_axi_n = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmp_release_busy got=%0b exp=0", busy); end
        checks++; if (out_vc_id !== 2'd0 || out_valid !== 1'b1) begin failures++; $display("FAIL rmp_release_vc got=vc%0d/v%0b exp=vc0/v1", out_vc_id, out_valid); end
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rmp_release_ready got=%b exp=0001", req_ready); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmp_post_busy got=%0b exp=0", busy); end
        checks++; if (out_vc_id !== 2'd1) begin failures++; $display("FAIL rmp_post_vc got=%0d exp=1", out_vc_id); end
    endtask

    initial begin
        rst_axi_n = 1'b0;
        vc_en     = '1;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < NumVC; i++) begin
            data_arr[i] = exp_data(2'(i));
            sz_arr[i]   = '0;
        end
        test_reset();
        test_two_vc_rr();
        test_ready_toggle();
        test_single_flit();
        test_vc_enable();
        test_valid_drop();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_vc_sched.md
# tx_vc_sched

Transmit virtual-channel scheduler sitting between the per-VC AXI write-side flit sources and the single to-NoC send port of the NI packet processor. It arbitrates round-robin among NumVC requesters at packet granularity. Once a head flit is granted, the owning VC keeps the port until its last flit is accepted, so flits of different packets never interleave on the local send link. A per-VC enable mask lets software take a VC out of arbitration.

## Interface
- NumVC, 2: number of requesting virtual channels (≥2).
- PktWidth, 8: width of packet-size field; pkt_sz = flits following the head flit.
- FlitDataWidth, 32: payload width per flit.
- clk_axi  in  1  AXI/NI clock.
- rst_axi_n  in  1  reset; synchronous, active-low.
- vc_en_i  in  NumVC  per-VC arbitration enable (config).
- req_valid_i  in  NumVC  per-VC flit valid.
- req_data_i  in  NumVC×FlitDataWidth  per-VC flit payload.
- req_pkt_sz_i  in  NumVC×PktWidth  per-VC packet size, held stable for a whole packet.
- req_ready_o  out  NumVC  per-VC accept (one-hot or zero).
- out_valid_o  out  1  flit valid toward packet processor.
- out_data_o  out  FlitDataWidth  granted payload.
- out_vc_id_o  out  VcWidth  granted VC, VcWidth = $clog2(NumVC).
- out_pkt_sz_o  out  PktWidth  granted packet size.
- out_ready_i  in  1  packet processor accept.
- busy_o  out  1  scheduler locked mid-packet.

## Operation
- State: IDLE, LOCKED. Registers: rr_ptr (VcWidth), grant_ff (VcWidth), cnt_ff (PktWidth).
- IDLE: candidates = req_valid_i & vc_en_i. The winner is the first candidate at or after rr_ptr, searching upward with wrap. The winner is forwarded combinationally in the same cycle. Accept = out_valid_o & out_ready_i.
  - On head accept with pkt_sz==0: stay IDLE; rr_ptr ← winner+1 mod NumVC.
  - On head accept with pkt_sz>0: go to LOCKED; grant_ff ← winner; cnt_ff ← pkt_sz.
  - No accept: no state change. The winner may change next cycle; no lock before acceptance.
- LOCKED: only grant_ff is forwarded; vc_en_i and other valids are ignored.
  - On accept with cnt_ff==1: go to IDLE; rr_ptr ← grant_ff+1 mod NumVC.
  - On accept otherwise: cnt_ff ← cnt_ff−1.
  - If req_valid_i[grant_ff] drops: out_valid_o=0; the scheduler stays locked and waits (no timeout).
- Clearing vc_en_i of the locked VC mid-packet does not abort the packet. The packet completes first.
- req_ready_o[i] = out_ready_i when i is the forwarded VC and the scheduler is in a forwarding state; else 0. out_* mirror the forwarded VC's inputs.
- out_pkt_sz_o passes the requester's value. Flit typing (head/body/tail) is done downstream.
- rr_ptr wraps modulo NumVC, including non-power-of-2 NumVC.
- Arithmetic: cnt_ff counts down only; it is never decremented below 1 while in LOCKED.

## Timing
- Reset (rst_axi_n=0 at a clk_axi edge): state IDLE, rr_ptr=0, grant_ff=0, cnt_ff=0.
- Output values during reset: out_valid_o=0, req_ready_o=0, busy_o=0, out_data_o=0, out_vc_id_o=0, out_pkt_sz_o=0.
- Reset mid-packet drops the lock immediately. The next cycle starts arbitration at VC 0.
- Latency: zero cycles from input to output. valid/data/ready are combinational through the mux.
- Arbitration decisions take effect at the next edge.
- busy_o = (state==LOCKED), registered.
- Throughput: one flit per cycle when out_ready_i is held high. There are no bubbles between packets, including back-to-back packets from different VCs.
- No combinational path from out_ready_i to out_valid_o.

## Structure
- Shared package (ravenoc_pkg) holds:
  - VcWidth.
  - tx_sched_st_t enum {IDLE, LOCKED}.
  - A s_vc_flit_req_t struct {valid, data, pkt_sz}, reused by the AXI-slave write buffers.
- One natural sub-module: rr_arbiter. It is purely combinational (request vector, pointer → one-hot grant + index) and is reusable by the RX-side VC arbiter.
- Expected size: ~180 lines RTL.

## Test plan
- VC0 and VC1 both valid, pkt_sz=2 each, out_ready_i=1 → VC0 flits at cycles 0–2, VC1 at cycles 3–5, no gap; busy_o high in cycles 1–2 and 4–5.
- VC1 locked with pkt_sz=3, VC0 valid throughout; out_ready_i toggles 1,0,1,0… → exactly 4 VC1 accepts before any VC0 flit; req_ready_o[0] stays 0.
- pkt_sz=0 single-flit packets on all 4 VCs (NumVC=4), continuous → grants 0,1,2,3,0 on consecutive cycles; busy_o never asserts.
- vc_en_i=4'b1101 with all valid → VC1 never granted. Clear vc_en_i[0] while VC0 is locked mid-packet → the packet finishes, then VC0 is skipped.
- Locked VC drops req_valid_i for 3 cycles → out_valid_o=0 for those cycles, other VCs blocked, cnt_ff unchanged, resume completes the packet.
- Assert rst_axi_n=0 mid-packet (cnt_ff=5) → next cycle all outputs 0, busy_o=0. After release, VC0 wins if valid.
